dlx_datamem: RTL and testbench



---
 rtl/dlx_datamem.sv | 121 ++++++++++++
 tb/tb_dlx_datamem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dlx_datamem.sv
// Word-organised data memory for the DLX memory-access stage.
// Clears every word after reset, then serves 1-cycle loads and stores,
// flagging misaligned or out-of-range byte addresses.
module dlx_datamem #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic              mem_en,
  input  logic              mem_rd,
  input  logic [DATA_W-1:0] memdata_out,
  output logic [DATA_W-1:0] memdata_in,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [ADDR_BITS-1:0] clr_idx, clr_idx_d;
  logic                busy_d, rd_valid_d, addr_err_d;
  logic [DATA_W-1:0]   memdata_in_d;

  logic                wr_en;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                misaligned, out_of_range, addr_ok;

  // Byte address decode into word index plus validity checks
  always_comb begin
    idx          = mem_addr[ADDR_BITS+1:2];
    misaligned   = |mem_addr[1:0];
    out_of_range = |mem_addr[31:ADDR_BITS+2];
    addr_ok      = ~misaligned & ~out_of_range;
  end

  // Next-state, array write port and output next-values
  always_comb begin
    state_d      = state;
    clr_idx_d    = clr_idx;
    busy_d       = busy;
    rd_valid_d   = 1'b0;
    addr_err_d   = 1'b0;
    memdata_in_d = memdata_in;
    wr_en        = 1'b0;
    wr_idx       = idx;
    wr_data      = memdata_out;
    case (state)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx;
        wr_data   = DATA_W'(0);
        clr_idx_d = clr_idx + 1'b1;
        busy_d    = 1'b1;
        // Last word written: leave the sweep rather than wrapping back to 0
        if (clr_idx == LAST_IDX) begin
          state_d   = RUN;
          busy_d    = 1'b0;
          clr_idx_d = '0;
        end
      end
      RUN: begin
        busy_d = 1'b0;
        if ((mem_en | mem_rd) & ~addr_ok) begin
          addr_err_d = 1'b1;
        end
        if (mem_en & addr_ok) begin
          wr_en = 1'b1;
        end
        // Same-word store and load resolve write-first
        if (mem_rd & addr_ok) begin
          rd_valid_d   = 1'b1;
          memdata_in_d = mem_en ? memdata_out : mem[idx];
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      busy       <= 1'b1;
      memdata_in <= '0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_d;
      clr_idx    <= clr_idx_d;
      busy       <= busy_d;
      memdata_in <= memdata_in_d;
      rd_valid   <= rd_valid_d;
      addr_err   <= addr_err_d;
    end
  end

  // Storage array; contents are cleared by the sweep, not by reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_dlx_datamem.sv
// Self-checking bench for dlx_datamem: directed scenarios followed by
// randomized traffic compared against a word-array reference model.
module tb_dlx_datamem;

  localparam int unsigned DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_en = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] memdata_out = '0;
  logic [31:0] memdata_in;
  logic        rd_valid;
  logic        busy;
  logic        addr_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  int          sweep_left = DEPTH;

  dlx_datamem dut (
    .clock       (clock),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_rd      (mem_rd),
    .memdata_out (memdata_out),
    .memdata_in  (memdata_in),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic; model follows the behavioural rules directly
  task automatic step(input logic [31:0] a, input logic en, input logic rd, input logic [31:0] d);
    bit ok;
    int i;
    mem_addr    = a;
    mem_en      = en;
    mem_rd      = rd;
    memdata_out = d;
    @(posedge clock);
    #1;
    if (sweep_left > 0) begin
      sweep_left--;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      ok        = (a % 4 == 0) && (a < 32'd1024);
      i         = int'(a / 4);
      exp_err   = (en || rd) && !ok;
      exp_valid = rd && ok;
      if (en && ok) model_mem[i] = d;
      if (exp_valid) exp_data = model_mem[i];
    end
    check("memdata_in", memdata_in, exp_data);
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("addr_err", 32'(addr_err), 32'(exp_err));
    check("busy", 32'(busy), 32'(sweep_left > 0));
  endtask

  task automatic idle();
    step(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Assert reset away from any edge, check outputs immediately, release
  task automatic do_reset();
    reset  = 1'b0;
    mem_en = 1'b0;
    mem_rd = 1'b0;
    #2;
    check("rst_memdata_in", memdata_in, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    sweep_left = DEPTH;
    foreach (model_mem[k]) model_mem[k] = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Run idle cycles until busy drops; total sweep cycles must equal DEPTH
  task automatic finish_sweep(input int used);
    int n;
    n = used;
    while (busy && n < 1000) begin
      idle();
      n++;
    end
    check("sweep_len", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;

    #6;
    do_reset();
    finish_sweep(0);

    // Post-sweep contents are zero at both ends of the array
    step(32'h0, 1'b0, 1'b1, 32'h0);
    check("ld0_zero", memdata_in, 32'h0);
    check("ld0_valid", 32'(rd_valid), 32'h1);
    step(32'h3FC, 1'b0, 1'b1, 32'h0);
    check("ld3fc_zero", memdata_in, 32'h0);

    // Store then load next cycle, then idle holds data
    step(32'h10, 1'b1, 1'b0, 32'hDEADBEEF);
    step(32'h10, 1'b0, 1'b1, 32'h0);
    check("ld10", memdata_in, 32'hDEADBEEF);
    idle();
    check("hold10", memdata_in, 32'hDEADBEEF);
    check("hold10_valid", 32'(rd_valid), 32'h0);

    // Same-cycle store and load is write-first
    step(32'h20, 1'b1, 1'b1, 32'h12345678);
    check("wf20", memdata_in, 32'h12345678);
    step(32'h20, 1'b0, 1'b1, 32'h0);
    check("ld20", memdata_in, 32'h12345678);

    // Misaligned store, then out-of-range load
    step(32'h13, 1'b1, 1'b0, 32'hAAAA5555);
    check("mis_err", 32'(addr_err), 32'h1);
    step(32'h10, 1'b0, 1'b1, 32'h0);
    check("mis_noalias", memdata_in, 32'hDEADBEEF);
    check("err_clear", 32'(addr_err), 32'h0);
    step(32'h400, 1'b0, 1'b1, 32'h0);
    check("oor_err", 32'(addr_err), 32'h1);
    check("oor_valid", 32'(rd_valid), 32'h0);

    // Reset at sweep cycle 100, then accesses while busy are ignored
    do_reset();
    for (int k = 0; k < 100; k++) idle();
    do_reset();
    step(32'h10, 1'b1, 1'b0, 32'h55AA55AA);
    step(32'h10, 1'b0, 1'b1, 32'h0);
    check("busy_ld_valid", 32'(rd_valid), 32'h0);
    finish_sweep(2);
    step(32'h10, 1'b0, 1'b1, 32'h0);
    check("after_sweep_10", memdata_in, 32'h0);

    // Reset in RUN clears outputs asynchronously and contents via sweep
    step(32'h40, 1'b1, 1'b0, 32'hCAFEF00D);
    step(32'h40, 1'b0, 1'b1, 32'h0);
    check("ld40", memdata_in, 32'hCAFEF00D);
    do_reset();
    finish_sweep(0);
    step(32'h40, 1'b0, 1'b1, 32'h0);
    check("ld40_cleared", memdata_in, 32'h0);

    // Randomized traffic over a small word window plus bad addresses
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, 15)) * 4;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = a | (32'($urandom_range(1, 255)) << 10);
      else if (sel == 2) a = 32'h3C0 + 32'($urandom_range(0, 15)) * 4;
      d = $urandom;
      step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
